// File: rtl/pcie_prp_cpld_rx.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_prp_cpld_rx
//  Function : Issues PRP memory-read requests through a 4-entry tag table and
//             forwards matching completion data, dropping bad completions.
//  Revision : 1.0 - initial release
// ============================================================================
module pcie_prp_cpld_rx #(
    parameter int C_PCIE_DATA_WIDTH = 512,
    parameter int C_PCIE_ADDR_WIDTH = 48
) (
    input  logic                           pcie_user_clk,
    input  logic                           pcie_user_rst_n,

    input  logic                           tx_prp_mrd_req,
    input  logic [7:0]                     tx_prp_mrd_tag,
    input  logic [12:2]                    tx_prp_mrd_len,
    input  logic [C_PCIE_ADDR_WIDTH-1:2]   tx_prp_mrd_addr,
    output logic                           tx_prp_mrd_req_ack,

    output logic                           mrd_tx_req,
    output logic [7:0]                     mrd_tx_tag,
    output logic [12:2]                    mrd_tx_len,
    output logic [C_PCIE_ADDR_WIDTH-1:2]   mrd_tx_addr,
    input  logic                           mrd_tx_ack,

    input  logic                           cpld_valid,
    input  logic                           cpld_sop,
    input  logic                           cpld_eop,
    input  logic [7:0]                     cpld_tag,
    input  logic [9:0]                     cpld_len,
    input  logic [2:0]                     cpld_status,
    input  logic [C_PCIE_DATA_WIDTH-1:0]   cpld_data,

    output logic [7:0]                     cpld_prp_fifo_tag,
    output logic [C_PCIE_DATA_WIDTH-1:0]   cpld_prp_fifo_wr_data,
    output logic                           cpld_prp_fifo_wr_en,
    output logic                           cpld_prp_fifo_tag_last,
    output logic                           cpld_err
);

    localparam int C_NUM_ENT = 4;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_FWD  = 2'd1,
        R_ACK  = 2'd2
    } req_state_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_DATA = 2'd1,
        C_DROP = 2'd2
    } cpl_state_t;

    req_state_t r_req_state;
    req_state_t w_req_state_nxt;
    cpl_state_t r_cpl_state;
    cpl_state_t w_cpl_state_nxt;

    logic        r_ent_valid [C_NUM_ENT];
    logic [10:0] r_ent_rem   [C_NUM_ENT];

    logic [7:0]                    r_mrd_tag;
    logic [12:2]                   r_mrd_len;
    logic [C_PCIE_ADDR_WIDTH-1:2]  r_mrd_addr;
    logic                          w_req_take;
    logic                          w_ins;
    logic [1:0]                    w_req_idx;

    logic [7:0]                    r_cpl_tag;
    logic                          r_cpl_last;
    logic                          r_wr_en;
    logic [C_PCIE_DATA_WIDTH-1:0]  r_wr_data;
    logic [7:0]                    r_fifo_tag;
    logic                          r_tag_last;
    logic                          r_err;

    logic [1:0]  w_cpl_idx;
    logic [10:0] w_cpl_len;
    logic [10:0] w_rem_sel;
    logic [10:0] w_rem_after;
    logic        w_cpl_bad;
    logic        w_fwd;
    logic [7:0]  w_fwd_tag;
    logic        w_fwd_last;
    logic        w_drop;
    logic        w_dec;
    logic        w_clr;
    logic [1:0]  w_clr_idx;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    assign w_req_idx = tx_prp_mrd_tag[1:0];

    always_comb begin
        w_req_state_nxt = r_req_state;
        w_req_take      = 1'b0;
        w_ins           = 1'b0;
        case (r_req_state)
            R_IDLE: begin
                // A tag slot still in flight blocks reuse until its data drains
                if (tx_prp_mrd_req && !r_ent_valid[w_req_idx]) begin
                    w_req_state_nxt = R_FWD;
                    w_req_take      = 1'b1;
                end
            end
            R_FWD: begin
                if (mrd_tx_ack) begin
                    w_req_state_nxt = R_ACK;
                    w_ins           = 1'b1;
                end
            end
            R_ACK:   w_req_state_nxt = R_IDLE;
            default: w_req_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            r_req_state <= R_IDLE;
            r_mrd_tag   <= '0;
            r_mrd_len   <= '0;
            r_mrd_addr  <= '0;
        end else begin
            r_req_state <= w_req_state_nxt;
            if (w_req_take) begin
                r_mrd_tag  <= tx_prp_mrd_tag;
                r_mrd_len  <= tx_prp_mrd_len;
                r_mrd_addr <= tx_prp_mrd_addr;
            end
        end
    end

    assign mrd_tx_req         = (r_req_state == R_FWD);
    assign tx_prp_mrd_req_ack = (r_req_state == R_ACK);
    assign mrd_tx_tag         = r_mrd_tag;
    assign mrd_tx_len         = r_mrd_len;
    assign mrd_tx_addr        = r_mrd_addr;

    // ------------------------------------------------------------------
    // Completion path
    // ------------------------------------------------------------------
    assign w_cpl_idx   = cpld_tag[1:0];
    assign w_cpl_len   = {1'b0, cpld_len};
    assign w_rem_sel   = r_ent_rem[w_cpl_idx];
    assign w_rem_after = w_rem_sel - w_cpl_len;
    assign w_cpl_bad   = !r_ent_valid[w_cpl_idx] || (cpld_status != 3'd0) ||
                         (w_cpl_len > w_rem_sel);

    always_comb begin
        w_cpl_state_nxt = r_cpl_state;
        w_fwd           = 1'b0;
        w_fwd_tag       = r_cpl_tag;
        w_fwd_last      = 1'b0;
        w_drop          = 1'b0;
        w_dec           = 1'b0;
        w_clr           = 1'b0;
        w_clr_idx       = r_cpl_tag[1:0];
        if (cpld_valid) begin
            case (r_cpl_state)
                C_IDLE: begin
                    // Beats without sop here are orphans and are ignored
                    if (cpld_sop) begin
                        if (w_cpl_bad) begin
                            w_drop = 1'b1;
                            if (!cpld_eop) begin
                                w_cpl_state_nxt = C_DROP;
                            end
                        end else begin
                            w_dec     = 1'b1;
                            w_fwd     = 1'b1;
                            w_fwd_tag = cpld_tag;
                            if (cpld_eop) begin
                                w_fwd_last = (w_rem_after == 11'd0);
                                w_clr      = w_fwd_last;
                                w_clr_idx  = w_cpl_idx;
                            end else begin
                                w_cpl_state_nxt = C_DATA;
                            end
                        end
                    end
                end
                C_DATA: begin
                    w_fwd = 1'b1;
                    if (cpld_eop) begin
                        w_cpl_state_nxt = C_IDLE;
                        w_fwd_last      = r_cpl_last;
                        w_clr           = r_cpl_last;
                    end
                end
                C_DROP: begin
                    if (cpld_eop) begin
                        w_cpl_state_nxt = C_IDLE;
                    end
                end
                default: w_cpl_state_nxt = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            r_cpl_state <= C_IDLE;
            r_cpl_tag   <= '0;
            r_cpl_last  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_fifo_tag  <= '0;
            r_tag_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cpl_state <= w_cpl_state_nxt;
            if (w_dec) begin
                r_cpl_tag  <= cpld_tag;
                r_cpl_last <= (w_rem_after == 11'd0);
            end
            r_wr_en    <= w_fwd;
            r_tag_last <= w_fwd_last;
            r_err      <= w_drop;
            if (w_fwd) begin
                r_wr_data  <= cpld_data;
                r_fifo_tag <= w_fwd_tag;
            end
        end
    end

    assign cpld_prp_fifo_wr_en    = r_wr_en;
    assign cpld_prp_fifo_wr_data  = r_wr_data;
    assign cpld_prp_fifo_tag      = r_fifo_tag;
    assign cpld_prp_fifo_tag_last = r_tag_last;
    assign cpld_err               = r_err;

    // ------------------------------------------------------------------
    // Tag table: insert and clear may hit different slots in one cycle
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < C_NUM_ENT; gi++) begin : g_ent
        always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
            if (!pcie_user_rst_n) begin
                r_ent_valid[gi] <= 1'b0;
                r_ent_rem[gi]   <= '0;
            end else begin
                if (w_ins && (r_mrd_tag[1:0] == 2'(gi))) begin
                    r_ent_valid[gi] <= 1'b1;
                    r_ent_rem[gi]   <= r_mrd_len;
                end
                if (w_dec && (w_cpl_idx == 2'(gi))) begin
                    r_ent_rem[gi] <= w_rem_after;
                end
                if (w_clr && (w_clr_idx == 2'(gi))) begin
                    r_ent_valid[gi] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcie_prp_cpld_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcie_prp_cpld_rx
//  Function : Directed and randomized bench for pcie_prp_cpld_rx against a
//             behavioural tag-table model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pcie_prp_cpld_rx;

    localparam int DW = 512;
    localparam int AW = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_prp_mrd_req = 1'b0;
    logic [7:0]    tx_prp_mrd_tag = '0;
    logic [12:2]   tx_prp_mrd_len = '0;
    logic [AW-1:2] tx_prp_mrd_addr = '0;
    logic          tx_prp_mrd_req_ack;
    logic          mrd_tx_req;
    logic [7:0]    mrd_tx_tag;
    logic [12:2]   mrd_tx_len;
    logic [AW-1:2] mrd_tx_addr;
    logic          mrd_tx_ack = 1'b1;
    logic          cpld_valid = 1'b0;
    logic          cpld_sop = 1'b0;
    logic          cpld_eop = 1'b0;
    logic [7:0]    cpld_tag = '0;
    logic [9:0]    cpld_len = '0;
    logic [2:0]    cpld_status = '0;
    logic [DW-1:0] cpld_data = '0;
    logic [7:0]    fifo_tag;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_wr_en;
    logic          fifo_tag_last;
    logic          cpld_err;

    always #5 clk = ~clk;

    pcie_prp_cpld_rx #(
        .C_PCIE_DATA_WIDTH (DW),
        .C_PCIE_ADDR_WIDTH (AW)
    ) u_dut (
        .pcie_user_clk          (clk),
        .pcie_user_rst_n        (rst_n),
        .tx_prp_mrd_req         (tx_prp_mrd_req),
        .tx_prp_mrd_tag         (tx_prp_mrd_tag),
        .tx_prp_mrd_len         (tx_prp_mrd_len),
        .tx_prp_mrd_addr        (tx_prp_mrd_addr),
        .tx_prp_mrd_req_ack     (tx_prp_mrd_req_ack),
        .mrd_tx_req             (mrd_tx_req),
        .mrd_tx_tag             (mrd_tx_tag),
        .mrd_tx_len             (mrd_tx_len),
        .mrd_tx_addr            (mrd_tx_addr),
        .mrd_tx_ack             (mrd_tx_ack),
        .cpld_valid             (cpld_valid),
        .cpld_sop               (cpld_sop),
        .cpld_eop               (cpld_eop),
        .cpld_tag               (cpld_tag),
        .cpld_len               (cpld_len),
        .cpld_status            (cpld_status),
        .cpld_data              (cpld_data),
        .cpld_prp_fifo_tag      (fifo_tag),
        .cpld_prp_fifo_wr_data  (fifo_wr_data),
        .cpld_prp_fifo_wr_en    (fifo_wr_en),
        .cpld_prp_fifo_tag_last (fifo_tag_last),
        .cpld_err               (cpld_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            m_valid [4];
    int            m_rem   [4];
    bit            m_in_tlp, m_tlp_ok, m_tlp_last;
    logic [7:0]    m_tlp_tag;
    bit            m_fwd, m_ackph;
    logic [7:0]    m_rq_tag;
    logic [12:2]   m_rq_len;
    logic [AW-1:2] m_rq_addr;
    bit            exp_wr_en, exp_last, exp_err, exp_mrd_req, exp_ack;
    logic [DW-1:0] exp_data;
    logic [7:0]    exp_tag;
    int            rq_cyc;
    bit            rq_chk_lat;
    bit            rand_ack;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_rem[i]   = 0;
        end
        m_in_tlp = 0; m_tlp_ok = 0; m_tlp_last = 0;
        m_fwd = 0; m_ackph = 0;
        exp_wr_en = 0; exp_last = 0; exp_err = 0; exp_mrd_req = 0; exp_ack = 0;
    endtask

    // Predicts the outputs visible after the coming clock edge from the
    // inputs presented now and the table contents before that edge.
    task automatic model_eval();
        int ci;
        bit nfwd, nack, ins;
        nfwd = m_fwd; nack = 0; ins = 0;
        if (m_fwd) begin
            if (mrd_tx_ack) begin
                nfwd = 0; nack = 1; ins = 1;
            end
        end else if (!m_ackph && tx_prp_mrd_req && !m_valid[tx_prp_mrd_tag[1:0]]) begin
            nfwd      = 1;
            m_rq_tag  = tx_prp_mrd_tag;
            m_rq_len  = tx_prp_mrd_len;
            m_rq_addr = tx_prp_mrd_addr;
        end

        exp_wr_en = 0; exp_last = 0; exp_err = 0;
        if (cpld_valid) begin
            if (!m_in_tlp && cpld_sop) begin
                ci         = int'(cpld_tag[1:0]);
                m_tlp_ok   = m_valid[ci] && (cpld_status == 3'd0) && (int'(cpld_len) <= m_rem[ci]);
                m_tlp_tag  = cpld_tag;
                m_tlp_last = 0;
                if (m_tlp_ok) begin
                    m_rem[ci]  = m_rem[ci] - int'(cpld_len);
                    m_tlp_last = (m_rem[ci] == 0);
                end else begin
                    exp_err = 1;
                end
                m_in_tlp = 1;
            end
            if (m_in_tlp) begin
                if (m_tlp_ok) begin
                    exp_wr_en = 1;
                    exp_data  = cpld_data;
                    exp_tag   = m_tlp_tag;
                end
                if (cpld_eop) begin
                    m_in_tlp = 0;
                    if (m_tlp_ok && m_tlp_last) begin
                        exp_last = 1;
                        m_valid[m_tlp_tag[1:0]] = 0;
                    end
                end
            end
        end

        if (ins) begin
            m_valid[m_rq_tag[1:0]] = 1;
            m_rem[m_rq_tag[1:0]]   = int'(m_rq_len);
        end
        m_fwd       = nfwd;
        m_ackph     = nack;
        exp_mrd_req = m_fwd;
        exp_ack     = m_ackph;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        check_eq("mrd_tx_req", mrd_tx_req, exp_mrd_req);
        check_eq("req_ack", tx_prp_mrd_req_ack, exp_ack);
        check_eq("wr_en", fifo_wr_en, exp_wr_en);
        check_eq("cpld_err", cpld_err, exp_err);
        check_eq("tag_last", fifo_tag_last, exp_last);
        if (exp_wr_en) begin
            check_eq("wr_data", fifo_wr_data, exp_data);
            check_eq("fifo_tag", fifo_tag, exp_tag);
        end
        if (exp_mrd_req) begin
            check_eq("mrd_tx_tag", mrd_tx_tag, m_rq_tag);
            check_eq("mrd_tx_len", mrd_tx_len, m_rq_len);
            check_eq("mrd_tx_addr", mrd_tx_addr, m_rq_addr);
        end
        if (tx_prp_mrd_req) begin
            rq_cyc++;
            if (tx_prp_mrd_req_ack) begin
                if (rq_chk_lat) check_eq("ack_latency", rq_cyc, 3);
                tx_prp_mrd_req = 1'b0;
            end
        end
        if (rand_ack) mrd_tx_ack = ($urandom_range(0, 3) != 0);
    endtask

    task automatic req_start(input logic [7:0] tag, input int len, input bit chk_lat);
        tx_prp_mrd_req  = 1'b1;
        tx_prp_mrd_tag  = tag;
        tx_prp_mrd_len  = 11'(len);
        tx_prp_mrd_addr = {$urandom, 14'($urandom)};
        rq_cyc          = 1;
        rq_chk_lat      = chk_lat;
    endtask

    task automatic wait_req_done(input int max_cycles);
        for (int i = 0; i < max_cycles && tx_prp_mrd_req; i++) tick();
        check_eq("req_done", tx_prp_mrd_req, 1'b0);
        tx_prp_mrd_req = 1'b0;
    endtask

    task automatic send_cpl(input logic [7:0] tag, input int len, input logic [2:0] st,
                            input int nbeats, input bit gaps);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
                    cpld_valid = 1'b0;
                    tick();
                end
            end
            cpld_valid  = 1'b1;
            cpld_sop    = (b == 0);
            cpld_eop    = (b == nbeats - 1);
            cpld_tag    = tag;
            cpld_len    = 10'(len);
            cpld_status = st;
            cpld_data   = rand_data();
            tick();
        end
        cpld_valid = 1'b0;
        cpld_sop   = 1'b0;
        cpld_eop   = 1'b0;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_mrd_tx_req"}, mrd_tx_req, 1'b0);
        check_eq({pfx, "_req_ack"}, tx_prp_mrd_req_ack, 1'b0);
        check_eq({pfx, "_wr_en"}, fifo_wr_en, 1'b0);
        check_eq({pfx, "_wr_data"}, fifo_wr_data, '0);
        check_eq({pfx, "_fifo_tag"}, fifo_tag, 8'h00);
        check_eq({pfx, "_tag_last"}, fifo_tag_last, 1'b0);
        check_eq({pfx, "_cpld_err"}, cpld_err, 1'b0);
    endtask

    task automatic drain_table();
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k]) send_cpl({6'h00, 2'(k)}, m_rem[k], 3'd0, 1, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        rand_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Request tag 1, 16 DW, then two 8-DW single-beat completions
        req_start(8'h01, 16, 1'b1);
        wait_req_done(10);
        send_cpl(8'h01, 8, 3'd0, 1, 1'b0);
        send_cpl(8'h01, 8, 3'd0, 1, 1'b0);

        // Completion to an unissued tag
        send_cpl(8'h02, 4, 3'd0, 3, 1'b0);
        tick();

        // Bad status leaves remaining intact; a good 8-DW completion then finishes it
        req_start(8'h03, 8, 1'b1);
        wait_req_done(10);
        send_cpl(8'h03, 8, 3'b001, 2, 1'b0);
        send_cpl(8'h03, 8, 3'd0, 2, 1'b1);

        // Same-slot request stalls until the outstanding tag drains
        req_start(8'h01, 4, 1'b1);
        wait_req_done(10);
        req_start(8'h05, 6, 1'b0);
        repeat (4) tick();
        send_cpl(8'h01, 4, 3'd0, 2, 1'b0);
        wait_req_done(10);
        send_cpl(8'h05, 6, 3'd0, 3, 1'b1);

        // Asynchronous reset mid-completion and mid-request
        req_start(8'h01, 32, 1'b1);
        wait_req_done(10);
        mrd_tx_ack = 1'b0;
        req_start(8'h02, 8, 1'b0);
        cpld_valid = 1'b1; cpld_sop = 1'b1; cpld_eop = 1'b0;
        cpld_tag = 8'h01; cpld_len = 10'd16; cpld_status = 3'd0; cpld_data = rand_data();
        tick();
        cpld_sop = 1'b0; cpld_data = rand_data();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        tx_prp_mrd_req = 1'b0;
        mrd_tx_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpld_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cpld_valid = 1'b1; cpld_sop = 1'b0; cpld_eop = 1'b0; cpld_data = rand_data();
        tick();
        cpld_eop = 1'b1; cpld_data = rand_data();
        tick();
        cpld_valid = 1'b0; cpld_eop = 1'b0;
        send_cpl(8'h01, 4, 3'd0, 1, 1'b0);
        req_start(8'h02, 8, 1'b1);
        wait_req_done(10);
        send_cpl(8'h02, 8, 3'd0, 2, 1'b0);

        // Randomized traffic with random transmit-side acceptance
        rand_ack = 1;
        for (int it = 0; it < 250; it++) begin
            int idx;
            int len;
            logic [2:0] st;
            if (!tx_prp_mrd_req && $urandom_range(0, 2) == 0)
                req_start({6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                          $urandom_range(1, 48), 1'b0);
            idx = $urandom_range(0, 3);
            if (m_valid[idx] && m_rem[idx] > 0 && $urandom_range(0, 4) != 0)
                len = ($urandom_range(0, 1) == 1) ? m_rem[idx] : $urandom_range(1, m_rem[idx]);
            else
                len = $urandom_range(1, 20);
            st = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            send_cpl({6'($urandom_range(0, 63)), 2'(idx)}, len, st, $urandom_range(1, 4), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_ack = 0;
        mrd_tx_ack = 1'b1;
        drain_table();
        wait_req_done(20);
        drain_table();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
